geofence_frame_feeder: RTL

Upstream stage of the geofence core. It accepts fence/target points from a valid/ready producer and assembles them into 7-point frames in a two-bank ping-pong buffer. It then streams each frame to the core as 7 consecutive X/Y beats, holding the next frame until the core reports its result. It also registers the core's result so downstream logic sees a stable verdict.

---
 rtl/geofence_frame_feeder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/geofence_frame_feeder.sv
// Ping-pong frame buffer feeding 7-beat X/Y frames (target + 6 fence points) to the geofence core.
// Define GF_FEEDER_STATS_EN to add the frame_cnt statistics port.
module geofence_frame_feeder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_x,
    input  logic [9:0] in_y,
    output logic       out_start,
    output logic       out_valid,
    output logic [9:0] X,
    output logic [9:0] Y,
    input  logic       core_valid,
    input  logic       core_inside,
    output logic       res_valid,
    output logic       res_inside,
    output logic       proto_err
`ifdef GF_FEEDER_STATS_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEND   = 2'd1;
    localparam logic [1:0] S_BUSY   = 2'd2;
    localparam logic [2:0] LAST_IDX = 3'd6;

    logic [19:0] r_mem [0:1][0:6];
    logic [1:0]  r_full;
    logic        r_wbank;
    logic        r_rbank;
    logic [2:0]  r_widx;
    logic [2:0]  r_ridx;
    logic [1:0]  r_state;

    logic        w_wr;
    logic        w_wr_last;
    logic        w_rd_last;
    logic [1:0]  w_set;
    logic [1:0]  w_clr;
    logic [19:0] w_rd_data;

    assign in_ready  = !r_full[r_wbank];
    assign w_wr      = in_valid && in_ready;
    assign w_wr_last = w_wr && (r_widx == LAST_IDX);
    assign w_rd_last = (r_state == S_SEND) && (r_ridx == LAST_IDX);
    // Fill and free always target different banks, so both may act in one cycle.
    assign w_set     = {w_wr_last && r_wbank, w_wr_last && !r_wbank};
    assign w_clr     = {w_rd_last && r_rbank, w_rd_last && !r_rbank};
    assign w_rd_data = r_mem[r_rbank][r_ridx];

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wbank][r_widx] <= {in_x, in_y};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wbank <= 1'b0;
            r_widx  <= 3'd0;
            r_full  <= 2'b00;
        end else begin
            r_full <= (r_full & ~w_clr) | w_set;
            if (w_wr) begin
                if (r_widx == LAST_IDX) begin
                    r_widx  <= 3'd0;
                    r_wbank <= !r_wbank;
                end else begin
                    r_widx <= r_widx + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rbank   <= 1'b0;
            r_ridx    <= 3'd0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            X         <= 10'd0;
            Y         <= 10'd0;
        end else begin
            out_valid <= 1'b0;
            out_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rbank]) begin
                        r_state <= S_SEND;
                        r_ridx  <= 3'd0;
                    end
                end
                S_SEND: begin
                    X         <= w_rd_data[19:10];
                    Y         <= w_rd_data[9:0];
                    out_valid <= 1'b1;
                    out_start <= (r_ridx == 3'd0);
                    if (r_ridx == LAST_IDX) begin
                        r_ridx  <= 3'd0;
                        r_rbank <= !r_rbank;
                        r_state <= S_BUSY;
                    end else begin
                        r_ridx <= r_ridx + 3'd1;
                    end
                end
                S_BUSY: begin
                    if (core_valid)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A result strobe outside BUSY is flagged and otherwise has no effect on the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid  <= 1'b0;
            res_inside <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            res_valid <= core_valid;
            if (core_valid)
                res_inside <= core_inside;
            if (core_valid && (r_state != S_BUSY))
                proto_err <= 1'b1;
        end
    end

`ifdef GF_FEEDER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_cnt <= 8'd0;
        else if ((r_state == S_SEND) && (r_ridx == 3'd0))
            frame_cnt <= frame_cnt + 8'd1;
    end
`endif

endmodule
